// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter that shares one multi-cycle FPU among NREQ requesters, one transaction at a time.
// Optional watchdog on the FPU wait phase is enabled by defining FPU_ARB_WDOG_EN.
//
// state   | meaning
// S_IDLE  | scan requests from ptr, grant first valid one, latch its operands
// S_ISSUE | one-cycle fpu_start pulse
// S_WAIT  | wait for fpu_done (or watchdog expiry)
// S_RESP  | present result to granted requester until it accepts
module fpu_rr_arbiter #(
    parameter int NREQ     = 4,
    parameter int W        = 32,
    parameter int WDOG_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_opa,
    input  logic [NREQ*W-1:0] req_opb,
    input  logic [NREQ*2-1:0] req_op,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_err,
    output logic              fpu_start,
    output logic [W-1:0]      fpu_opa,
    output logic [W-1:0]      fpu_opb,
    output logic [1:0]        fpu_op,
    input  logic              fpu_done,
    input  logic [W-1:0]      fpu_res
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   gnt_q;
    logic [PW-1:0]   pick;
    logic            any_req;
    logic [NREQ-1:0] gnt_onehot;
    logic            grant;
    logic            capture;
    logic            timeout;
    logic            accept;
    logic            wdog_hit;

    // Rotating priority scan starting at ptr_q.
    always_comb begin
        int idx;
        any_req = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                pick    = PW'(idx);
            end
        end
    end

    always_comb begin
        gnt_onehot        = '0;
        gnt_onehot[gnt_q] = 1'b1;
    end

`ifdef FPU_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG_CYC + 1);
    localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYC - 1);

    logic [CW-1:0] wdog_cnt;

    // Cleared while issuing so the first WAIT cycle sees zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (state_q == S_ISSUE) begin
            wdog_cnt <= '0;
        end else if (state_q == S_WAIT) begin
            wdog_cnt <= wdog_cnt + CW'(1);
        end
    end

    assign wdog_hit = (wdog_cnt == WDOG_LAST);
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        fpu_start = 1'b0;
        grant     = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    req_ready[pick] = 1'b1;
                    grant           = 1'b1;
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fpu_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the watchdog's last cycle still wins.
                if (fpu_done) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end else if (wdog_hit) begin
                    timeout = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[gnt_q]) begin
                    accept  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            gnt_q     <= '0;
            fpu_opa   <= '0;
            fpu_opb   <= '0;
            fpu_op    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (grant) begin
                gnt_q   <= pick;
                fpu_opa <= req_opa[int'(pick)*W +: W];
                fpu_opb <= req_opb[int'(pick)*W +: W];
                fpu_op  <= req_op[int'(pick)*2 +: 2];
            end
            if (capture) begin
                rsp_data  <= fpu_res;
                rsp_err   <= 1'b0;
                rsp_valid <= gnt_onehot;
            end
            if (timeout) begin
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
                rsp_valid <= gnt_onehot;
            end
            if (accept) begin
                rsp_valid <= '0;
                ptr_q     <= (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
            end
        end
    end

    a_params: assert property (@(posedge clk) (NREQ >= 1) && (WDOG_CYC >= 1));

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));

    a_rsp_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(rsp_valid));

    a_no_grant_while_rsp: assert property (@(posedge clk) disable iff (rst)
        !((|req_ready) && (|rsp_valid)));

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// Directed self-checking bench for fpu_rr_arbiter (NREQ=4, W=32, WDOG_CYC=8).
// Covers single request, round-robin fairness, backpressure, reset mid-op, spurious done and watchdog.
module tb_fpu_rr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_opa;
    logic [NREQ*W-1:0] req_opb;
    logic [NREQ*2-1:0] req_op;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              fpu_start;
    logic [W-1:0]      fpu_opa;
    logic [W-1:0]      fpu_opb;
    logic [1:0]        fpu_op;
    logic              fpu_done;
    logic [W-1:0]      fpu_res;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] opa_tab [NREQ];
    logic [W-1:0] opb_tab [NREQ];
    logic [1:0]   op_tab  [NREQ];

    fpu_rr_arbiter #(.NREQ(NREQ), .W(W), .WDOG_CYC(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_opa   (req_opa),
        .req_opb   (req_opb),
        .req_op    (req_op),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .fpu_start (fpu_start),
        .fpu_opa   (fpu_opa),
        .fpu_opb   (fpu_opb),
        .fpu_op    (fpu_op),
        .fpu_done  (fpu_done),
        .fpu_res   (fpu_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE slot with req_valid already set. dly = cycles from
    // fpu_start to fpu_done; hold = RESP cycles with the granted rsp_ready low.
    task automatic run_txn(input int g, input logic [W-1:0] res, input int dly,
                           input int hold, input bit drop, input bit spur);
        logic [NREQ-1:0] oh;
        oh = 4'b0001 << g;
        rsp_ready = (hold > 0) ? ~oh : 4'b1111;
        #1;
        check_eq("grant", req_ready, oh);
        step();
        if (drop) req_valid[g] = 1'b0;
        if (spur) begin
            fpu_done = 1'b1;
            fpu_res  = 32'hBAD0BAD0;
        end
        #1;
        check_eq("issue_start", fpu_start, 1);
        check_eq("issue_opa", fpu_opa, opa_tab[g]);
        check_eq("issue_opb", fpu_opb, opb_tab[g]);
        check_eq("issue_op", fpu_op, op_tab[g]);
        check_eq("issue_ready", req_ready, 0);
        for (int i = 1; i <= dly; i++) begin
            step();
            fpu_done = 1'b0;
            if (i == dly) begin
                fpu_done = 1'b1;
                fpu_res  = res;
            end
            #1;
            check_eq("wait_quiet", {rsp_valid, fpu_start, req_ready}, 0);
        end
        step();
        fpu_done = 1'b0;
        fpu_res  = 32'hFFFF_FFFF;
        #1;
        check_eq("rsp_valid", rsp_valid, oh);
        check_eq("rsp_data", rsp_data, res);
        check_eq("rsp_err", rsp_err, 0);
        check_eq("rsp_ready_quiet", {req_ready, fpu_start}, 0);
        for (int h = 0; h < hold; h++) begin
            step();
            #1;
            check_eq("bp_valid", rsp_valid, oh);
            check_eq("bp_data", rsp_data, res);
            check_eq("bp_quiet", {req_ready, fpu_start}, 0);
        end
        rsp_ready = 4'b1111;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        opa_tab = '{32'h3F800000, 32'h11110001, 32'h22220002, 32'h33330003};
        opb_tab = '{32'h40000000, 32'h11110010, 32'h22220020, 32'h33330030};
        op_tab  = '{2'd0, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < NREQ; i++) begin
            req_opa[i*W +: W] = opa_tab[i];
            req_opb[i*W +: W] = opb_tab[i];
            req_op[i*2 +: 2]  = op_tab[i];
        end
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 4'b1111;
        fpu_done  = 1'b0;
        fpu_res   = '0;
        step();
        step();
        #1;
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_start", fpu_start, 0);
        check_eq("rst_fpu_ops", {fpu_opa, fpu_opb, fpu_op}, 0);
        rst = 1'b0;
        step();

        // T1: single request, done 3 cycles after start
        req_valid = 4'b0001;
        run_txn(0, 32'h40400000, 3, 0, 1'b1, 1'b0);
        #1;
        check_eq("t1_idle_ready", req_ready, 0);
        check_eq("t1_rsp_cleared", rsp_valid, 0);
        check_eq("t1_data_held", rsp_data, 32'h40400000);

        // T2: fairness from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_eq("t2_rst_data", rsp_data, 0);
        req_valid = 4'b1111;
        run_txn(0, 32'hA0000000, 1, 0, 1'b0, 1'b0);
        run_txn(1, 32'hA0000001, 1, 0, 1'b0, 1'b0);
        run_txn(2, 32'hA0000002, 1, 0, 1'b0, 1'b0);
        run_txn(3, 32'hA0000003, 1, 0, 1'b0, 1'b0);
        run_txn(0, 32'hA0000004, 1, 0, 1'b0, 1'b0);
        run_txn(1, 32'hA0000005, 1, 0, 1'b0, 1'b0);
        req_valid = 4'b1010;
        run_txn(3, 32'hA0000006, 1, 0, 1'b0, 1'b0);
        run_txn(1, 32'hA0000007, 1, 0, 1'b0, 1'b0);

        // T3: backpressure on requester 2 with everyone else pending
        req_valid = 4'b1111;
        run_txn(2, 32'hB0000002, 2, 5, 1'b0, 1'b0);

        // T4: reset during WAIT with ptr at 3
        req_valid = 4'b1000;
        rsp_ready = 4'b1111;
        #1;
        check_eq("t4_grant", req_ready, 4'b1000);
        step();
        req_valid = 4'b0000;
        step();
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        fpu_done = 1'b1;
        fpu_res  = 32'hDEADBEEF;
        #1;
        check_eq("t4_outputs_zero", {req_ready, rsp_valid, rsp_err, fpu_start}, 0);
        check_eq("t4_data_zero", rsp_data, 0);
        check_eq("t4_opa_zero", fpu_opa, 0);
        step();
        fpu_done = 1'b0;
        #1;
        check_eq("t4_late_done_valid", rsp_valid, 0);
        check_eq("t4_late_done_data", rsp_data, 0);
        req_valid = 4'b1111;
        run_txn(0, 32'hC0000000, 1, 0, 1'b0, 1'b0);

        // T5: spurious done in IDLE, then during the ISSUE cycle
        req_valid = 4'b0000;
        fpu_done  = 1'b1;
        fpu_res   = 32'h12345678;
        step();
        fpu_done = 1'b0;
        #1;
        check_eq("t5_idle_valid", rsp_valid, 0);
        check_eq("t5_idle_data", rsp_data, 32'hC0000000);
        check_eq("t5_idle_start", fpu_start, 0);
        step();
        #1;
        check_eq("t5_idle_still", {rsp_valid, fpu_start, req_ready}, 0);
        req_valid = 4'b0010;
        run_txn(1, 32'hD0000001, 2, 0, 1'b1, 1'b1);

        // T6: watchdog
        req_valid = 4'b0100;
        rsp_ready = 4'b1111;
        #1;
        check_eq("t6_grant", req_ready, 4'b0100);
        step();
        req_valid = 4'b0000;
`ifdef FPU_ARB_WDOG_EN
        for (int i = 1; i <= 8; i++) begin
            step();
            #1;
            check_eq("t6_wait", rsp_valid, 0);
        end
        step();
        #1;
        check_eq("t6_to_valid", rsp_valid, 4'b0100);
        check_eq("t6_to_err", rsp_err, 1);
        check_eq("t6_to_data", rsp_data, 0);
        step();
        #1;
        check_eq("t6_to_cleared", rsp_valid, 0);
        req_valid = 4'b1000;
        run_txn(3, 32'h55AA55AA, 8, 0, 1'b1, 1'b0);
`else
        for (int i = 1; i <= 100; i++) begin
            step();
            #1;
            check_eq("t6_wait_forever", {rsp_valid, rsp_err}, 0);
        end
        fpu_done = 1'b1;
        fpu_res  = 32'h66006600;
        step();
        fpu_done = 1'b0;
        #1;
        check_eq("t6_late_valid", rsp_valid, 4'b0100);
        check_eq("t6_late_data", rsp_data, 32'h66006600);
        check_eq("t6_late_err", rsp_err, 0);
        step();
        #1;
        check_eq("t6_late_cleared", rsp_valid, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
